font_fetch_arbiter: RTL

Shares the single-port, one-cycle-latency font memory between two requesters. The display pixel pipeline has strict priority and fixed latency. An auxiliary requester (bus readback/overlay) uses a valid/ready handshake. The block sits between the text-mode renderer and the font memory, drives the memory address, and routes each registered memory word back to the requester that issued it. For display reads, it extracts the requested 8-pixel glyph row.

---
 rtl/font_fetch_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/font_fetch_arbiter.sv
// rtl/font_fetch_arbiter.sv - font memory arbiter: fixed-latency display reads plus a handshaked aux reader
module font_fetch_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int ROW_WIDTH  = 8,
  parameter int ROWS       = 16,
  parameter int DATA_WIDTH = ROW_WIDTH * ROWS,
  parameter int ROW_SEL_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  disp_req_i,
  input  logic [ADDR_WIDTH-1:0] disp_char_i,
  input  logic [ROW_SEL_W-1:0]  disp_row_i,
  output logic                  disp_valid_o,
  output logic [0:ROW_WIDTH-1]  disp_pixels_o,
  input  logic                  aux_req_valid_i,
  output logic                  aux_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] aux_addr_i,
  output logic                  aux_rsp_valid_o,
  input  logic                  aux_rsp_ready_i,
  output logic [0:DATA_WIDTH-1] aux_rsp_data_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [0:DATA_WIDTH-1] mem_dout_i
);

  localparam int BASE_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_INFLIGHT = 2'd1;
  localparam logic [1:0] S_RESP     = 2'd2;

  logic [1:0]            r_aux_state;
  logic                  r_disp_pend;
  logic [ROW_SEL_W-1:0]  r_row;
  logic                  r_disp_valid;
  logic [0:ROW_WIDTH-1]  r_disp_pixels;
  logic                  r_aux_rsp_valid;
  logic [0:DATA_WIDTH-1] r_aux_rsp_data;

  logic                  w_aux_ready;
  logic                  w_aux_grant;
  logic [BASE_W-1:0]     w_row_base;

  // Aux may only take the memory when the display is silent and no aux word is outstanding.
  assign w_aux_ready = rstn_i & ~disp_req_i & (r_aux_state == S_IDLE);
  assign w_aux_grant = w_aux_ready & aux_req_valid_i;
  assign w_row_base  = BASE_W'(r_row) * BASE_W'(ROW_WIDTH);

  // Memory address mux: display first, then aux, otherwise park at zero.
  always_comb begin
    mem_addr_o = '0;
    if (disp_req_i) begin
      mem_addr_o = disp_char_i;
    end else if (w_aux_grant) begin
      mem_addr_o = aux_addr_i;
    end
  end

  // Remember which display request owns the word arriving next cycle, and pick its row.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_disp_pend   <= 1'b0;
      r_row         <= '0;
      r_disp_valid  <= 1'b0;
      r_disp_pixels <= '0;
    end else begin
      r_disp_pend  <= disp_req_i;
      r_row        <= disp_row_i;
      r_disp_valid <= r_disp_pend;
      if (r_disp_pend) begin
        r_disp_pixels <= mem_dout_i[w_row_base +: ROW_WIDTH];
      end
    end
  end

  // Aux transaction sequencer: one word outstanding, captured only in the cycle after its grant.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_aux_state     <= S_IDLE;
      r_aux_rsp_valid <= 1'b0;
      r_aux_rsp_data  <= '0;
    end else begin
      case (r_aux_state)
        S_IDLE: begin
          if (w_aux_grant) begin
            r_aux_state <= S_INFLIGHT;
          end
        end
        S_INFLIGHT: begin
          r_aux_rsp_data  <= mem_dout_i;
          r_aux_rsp_valid <= 1'b1;
          r_aux_state     <= S_RESP;
        end
        S_RESP: begin
          if (aux_rsp_ready_i) begin
            r_aux_rsp_valid <= 1'b0;
            r_aux_state     <= S_IDLE;
          end
        end
        default: begin
          r_aux_rsp_valid <= 1'b0;
          r_aux_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign aux_req_ready_o = w_aux_ready;
  assign disp_valid_o    = r_disp_valid;
  assign disp_pixels_o   = r_disp_pixels;
  assign aux_rsp_valid_o = r_aux_rsp_valid;
  assign aux_rsp_data_o  = r_aux_rsp_data;

endmodule
